// File: rtl/nanocalc_pkg.sv
// Shared constants for the nanocalc calculator: opcodes, flag bit positions,
// the fixed pad-direction value and the divider state encoding.
package nanocalc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_SHL = 3'd7
  } op_e;

  localparam int unsigned FLAG_BUSY  = 7;
  localparam int unsigned FLAG_ERR   = 6;
  localparam int unsigned FLAG_CARRY = 5;
  localparam int unsigned FLAG_ZERO  = 4;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  typedef enum logic {
    DIV_IDLE,
    DIV_RUN
  } div_state_e;

endpackage

// File: rtl/nanocalc_if.sv
// Pin bundle of the nanocalc tile (everything except clk/reset).
interface nanocalc_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/nanocalc_div.sv
// 4-bit restoring divider, one quotient bit per cycle; the fourth step is
// presented combinationally with done so the result lands at start edge + 4.
module nanocalc_div
  import nanocalc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder
);

  div_state_e state_q, state_d;
  logic [3:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [1:0] cnt_q, cnt_d;

  logic [4:0] trial, diff;
  logic       fits;
  logic [3:0] rem_step, quo_step;

  always_comb begin
    trial    = {rem_q, quo_q[3]};
    diff     = trial - {1'b0, dvs_q};
    fits     = (trial >= {1'b0, dvs_q});
    rem_step = fits ? diff[3:0] : trial[3:0];
    quo_step = {quo_q[2:0], fits};
  end

  assign busy      = (state_q == DIV_RUN);
  assign done      = (state_q == DIV_RUN) && (cnt_q == 2'd3);
  assign quotient  = quo_step;
  assign remainder = rem_step;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d = DIV_RUN;
          rem_d   = '0;
          quo_d   = dividend;
          dvs_d   = divisor;
          cnt_d   = '0;
        end
      end
      DIV_RUN: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_um_nanocalc.sv
// Nanocalc tile: edge-triggered 4-bit ALU with registered result and flags;
// non-zero DIV is delegated to the sequential divider.
module tt_um_nanocalc
  import nanocalc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] a, b;
  op_e        op;
  logic       go, go_q, go_d;
  logic       start, div_start;
  logic       div_busy, div_done;
  logic [3:0] div_quo, div_rem;
  logic [7:0] res_q, res_d, alu_res;
  logic       err_q, err_d, carry_q, carry_d, zero_q, zero_d;
  logic       alu_carry, alu_err;
  logic [4:0] sum;
  logic       unused_uio_hi;

  assign a             = ui_in[3:0];
  assign b             = ui_in[7:4];
  assign op            = op_e'(uio_in[2:0]);
  assign go            = uio_in[3];
  assign unused_uio_hi = ^uio_in[7:4];

  assign start     = go && !go_q && ena && !div_busy;
  assign div_start = start && (op == OP_DIV) && (b != 4'd0);

  nanocalc_div u_div (
    .clk       (clk),
    .rst       (rst_n),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = {3'b000, sum};
        alu_carry = sum[4];
      end
      OP_SUB: begin
        alu_res   = {4'h0, a} - {4'h0, b};
        alu_carry = (a < b);
      end
      OP_MUL: alu_res = {4'h0, a} * {4'h0, b};
      OP_DIV: begin
        // only reached for B=0; non-zero divisors go through u_div
        alu_res = 8'hFF;
        alu_err = 1'b1;
      end
      OP_AND: alu_res = {4'h0, a & b};
      OP_OR:  alu_res = {4'h0, a | b};
      OP_XOR: alu_res = {4'h0, a ^ b};
      OP_SHL: alu_res = {4'h0, a} << b[2:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    go_d    = go;
    res_d   = res_q;
    err_d   = err_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (div_done) begin
      res_d   = {div_rem, div_quo};
      err_d   = 1'b0;
      carry_d = 1'b0;
      zero_d  = ({div_rem, div_quo} == 8'h00);
    end else if (start && !div_start) begin
      res_d   = alu_res;
      err_d   = alu_err;
      carry_d = alu_carry;
      zero_d  = (alu_res == 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      go_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      go_q    <= go_d;
      res_q   <= res_d;
      err_q   <= err_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    uio_out             = '0;
    uio_out[FLAG_BUSY]  = div_busy;
    uio_out[FLAG_ERR]   = err_q;
    uio_out[FLAG_CARRY] = carry_q;
    uio_out[FLAG_ZERO]  = zero_q;
  end

  assign uo_out = res_q;
  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_nanocalc.sv
// Self-checking bench for tt_um_nanocalc: directed scenarios plus a random
// run against a transaction-level reference model.
module tb_tt_um_nanocalc;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  nanocalc_if bus ();

  tt_um_nanocalc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uo_out  (bus.uo_out),
    .uio_in  (bus.uio_in),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] m_out, m_pend;
  logic       m_busy, m_err, m_carry, m_zero, m_go_q;
  int         m_cnt;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_calc(input int op, input int a, input int b,
                          output logic [7:0] r, output logic c, output logic e);
    int ri;
    c  = 1'b0;
    e  = 1'b0;
    ri = 0;
    case (op)
      0: begin ri = a + b; c = (a + b) > 15; end
      1: begin ri = (a - b) & 255; c = (a < b); end
      2: ri = a * b;
      3: begin ri = 255; e = 1'b1; end
      4: ri = a & b;
      5: ri = a | b;
      6: ri = a ^ b;
      default: ri = (a << (b % 8)) & 255;
    endcase
    r = 8'(ri);
  endtask

  task automatic model_step();
    int         a, b, op;
    logic       go, st, c, e;
    logic [7:0] r;
    if (rst_n) begin
      m_out = '0; m_busy = 0; m_err = 0; m_carry = 0; m_zero = 0;
      m_go_q = 0; m_cnt = 0;
      return;
    end
    a  = int'(bus.ui_in[3:0]);
    b  = int'(bus.ui_in[7:4]);
    op = int'(bus.uio_in[2:0]);
    go = bus.uio_in[3];
    st = go && !m_go_q && bus.ena && !m_busy;
    m_go_q = go;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0; m_out = m_pend; m_err = 0; m_carry = 0; m_zero = (m_pend == 0);
      end
    end else if (st) begin
      if (op == 3 && b != 0) begin
        m_busy = 1;
        m_cnt  = 4;
        m_pend = 8'((a % b) * 16 + a / b);
      end else begin
        ref_calc(op, a, b, r, c, e);
        m_out = r; m_err = e; m_carry = c; m_zero = (r == 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("uo_out", bus.uo_out, m_out);
    check("uio_out", bus.uio_out, {m_busy, m_err, m_carry, m_zero, 4'h0});
    check("uio_oe", bus.uio_oe, 8'hF0);
  endtask

  task automatic drive(input int op, input int a, input int b, input logic go);
    bus.ui_in  = {4'(b), 4'(a)};
    bus.uio_in = {4'($urandom_range(0, 15)), go, 3'(op)};
  endtask

  initial begin
    m_out = '0; m_pend = '0; m_busy = 0; m_err = 0; m_carry = 0; m_zero = 0;
    m_go_q = 0; m_cnt = 0;
    rst_n   = 1'b1;
    bus.ena = 1'b1;
    drive(0, 0, 0, 1'b0);
    @(negedge clk);
    tick();
    tick();
    check("rst_uo", bus.uo_out, 8'h00);
    check("rst_flags", bus.uio_out, 8'h00);
    rst_n = 1'b0;

    drive(0, 9, 8, 1'b1); tick();
    check("add_9_8", bus.uo_out, 8'h11);
    check("add_flags", bus.uio_out, 8'h20);
    drive(0, 9, 8, 1'b0); tick();

    drive(1, 3, 5, 1'b1); tick();
    check("sub_3_5", bus.uo_out, 8'hFE);
    check("sub_borrow", bus.uio_out, 8'h20);
    drive(1, 3, 5, 1'b0); tick();
    drive(1, 5, 5, 1'b1); tick();
    check("sub_5_5", bus.uo_out, 8'h00);
    check("sub_zero", bus.uio_out, 8'h10);
    drive(1, 5, 5, 1'b0); tick();

    drive(2, 15, 15, 1'b1); tick();
    check("mul_15_15", bus.uo_out, 8'hE1);
    drive(2, 15, 15, 1'b0); tick();
    drive(7, 15, 7, 1'b1); tick();
    check("shl_f_7", bus.uo_out, 8'h80);
    check("shl_flags", bus.uio_out, 8'h00);
    drive(7, 15, 7, 1'b0); tick();

    // DIV 13/4 with a go re-pulse while busy
    for (int i = 0; i < 4; i++) begin
      drive(3, 13, 4, (i % 2) == 0); tick();
      check("div_busy", bus.uio_out, 8'h80);
      check("div_hold", bus.uo_out, 8'h80);
    end
    drive(3, 13, 4, 1'b0); tick();
    check("div_13_4", bus.uo_out, 8'h13);
    check("div_done_flags", bus.uio_out, 8'h00);
    tick(); tick();
    check("div_no_requeue", bus.uio_out, 8'h00);

    // DIV by zero with go held for 10 cycles; operands change underneath
    drive(3, 7, 0, 1'b1); tick();
    check("div0_res", bus.uo_out, 8'hFF);
    check("div0_flags", bus.uio_out, 8'h40);
    for (int i = 0; i < 9; i++) begin
      drive(0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b1); tick();
      check("go_held", bus.uo_out, 8'hFF);
    end
    drive(0, 1, 1, 1'b0); tick();

    // reset on cycle 2 of a DIV aborts it
    drive(3, 13, 4, 1'b1); tick();
    drive(3, 13, 4, 1'b0); tick();
    rst_n = 1'b1; tick();
    check("abort_uo", bus.uo_out, 8'h00);
    check("abort_flags", bus.uio_out, 8'h00);
    check("abort_oe", bus.uio_oe, 8'hF0);
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("abort_no_result", bus.uo_out, 8'h00);
    check("abort_no_busy", bus.uio_out, 8'h00);

    // ena low blocks a start
    bus.ena = 1'b0;
    drive(0, 2, 3, 1'b1); tick();
    check("ena_low", bus.uo_out, 8'h00);
    drive(0, 2, 3, 1'b0); tick();
    bus.ena = 1'b1;

    // reset wins over a go edge; go seen at first edge after release
    rst_n = 1'b1;
    drive(0, 1, 2, 1'b1); tick();
    check("rst_priority", bus.uo_out, 8'h00);
    rst_n = 1'b0; tick();
    check("go_after_rst", bus.uo_out, 8'h03);
    drive(0, 1, 2, 1'b0); tick();

    for (int i = 0; i < 600; i++) begin
      bus.ena = ($urandom_range(0, 7) != 0);
      rst_n   = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 7), $urandom_range(0, 15),
            ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15),
            ($urandom_range(0, 9) < 4));
      tick();
    end
    rst_n = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_nanocalc.md
TT_UM_NANOCALC -- requirements
Module: tt_um_nanocalc

Interface
- REQ-001: Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
- REQ-002: clk  input  1  sole clock; all state changes on its rising edge.
- REQ-003: rst_n  input  1  synchronous reset, active-high; the port name is retained for harness compatibility; rst_n=1 at a clk edge resets the block.
- REQ-004: ena  input  1  design enable; while 0, no new operation starts and any running operation continues.
- REQ-005: ui_in  input  8  operands: A=ui_in[3:0], B=ui_in[7:4], both unsigned.
- REQ-006: uo_out  output  8  registered result.
- REQ-007: uio_in  input  8  uio_in[2:0]=opcode, uio_in[3]=go; bits [7:4] ignored.
- REQ-008: uio_out  output  8  [7]=busy, [6]=err, [5]=carry/borrow, [4]=zero; bits [3:0] SHALL be 0.
- REQ-009: uio_oe  output  8  SHALL be the constant 8'hF0.
- REQ-010: Opcode constants: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, SHL=7.

Function
- REQ-011: go SHALL be registered into go_q every cycle; a start SHALL occur at an edge where go=1, go_q=0, ena=1 and busy=0.
- REQ-012: A start is edge-triggered: holding go high SHALL produce exactly one operation.
- REQ-013: Operands and opcode SHALL be sampled only at the start edge.
- REQ-014: Non-DIV ops, and DIV with B=0, SHALL update uo_out and all flags at the start edge, giving one-cycle latency.
- REQ-015: ADD result: A+B, zero-extended to 8 bits; carry=result[4].
- REQ-016: SUB result: A-B as 8-bit two's complement; carry=1 iff A<B (borrow).
- REQ-017: MUL result: A*B as 8 bits.
- REQ-018: AND/OR/XOR result: the bitwise result in [3:0], with [7:4]=0.
- REQ-019: SHL result: ({4'b0,A} << B[2:0]) truncated to 8 bits.
- REQ-020: carry SHALL be 0 for every op other than ADD and SUB.
- REQ-021: DIV with B!=0 SHALL run a restoring divider for 4 cycles: busy=1 from the start edge, result and flags at start edge+4, busy=0 at that same edge.
- REQ-022: DIV result SHALL be {remainder[3:0], quotient[3:0]}.
- REQ-023: DIV with B=0: uo_out=8'hFF, err=1, busy never set.
- REQ-024: err SHALL be 0 for every other op; err is cleared by the next start.
- REQ-025: zero SHALL be 1 iff the newly written 8-bit result is 0.
- REQ-026: While busy=1, uo_out and flags [6:4] SHALL hold their previous values; go edges during busy SHALL be ignored, not queued.
- REQ-027: Between operations all outputs SHALL hold.

Reset
- REQ-028: On reset, uo_out=0, uio_out=0 (busy/err/carry/zero=0), go_q=0, and divider state cleared.
- REQ-029: Reset during a DIV SHALL abort it, with no result written.
- REQ-030: A go edge is detectable at the first edge after reset deasserts if go=1 there (go_q=0 after reset).
- REQ-031: Reset SHALL take priority over a simultaneous start.

Structure
- REQ-032: Opcode constants and the flag bit positions SHALL live in the shared package nanocalc_pkg.
- REQ-033: The sequential divider SHALL be one sub-module, nanocalc_div, with ports: start, dividend[3:0], divisor[3:0], busy, done, quotient[3:0], remainder[3:0].
- REQ-034: All other ALU logic SHALL be combinational in the top module, with a registered output.

Verification
- REQ-035: A=9, B=8, ADD, go pulse -> uo_out=0x11, carry=1, zero=0, one cycle later.
- REQ-036: A=3, B=5, SUB -> uo_out=0xFE, carry=1; then A=5, B=5, SUB -> uo_out=0x00, zero=1, carry=0.
- REQ-037: A=15, B=15, MUL -> uo_out=0xE1; SHL with A=0xF, B=7 -> uo_out=0x80.
- REQ-038: A=13, B=4, DIV -> busy=1 for 4 cycles, then uo_out=0x13, busy=0; go re-pulsed mid-DIV is ignored.
- REQ-039: DIV with B=0 -> uo_out=0xFF, err=1, busy stays 0; go held high for 10 cycles -> exactly one update.
- REQ-040: Reset asserted on cycle 2 of a DIV -> all outputs 0, uio_oe=0xF0, and no later result appears.
